// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Multi-cycle WIDTH-bit adder that feeds one 4-bit slice per clock through a
// single 4-bit add, least significant slice first. The carry between slices is
// held in a register. Operands come in on a valid/ready handshake and the
// result goes out on another valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [IW-1:0]     idx_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              out_valid_r;
  logic              busy_r;

  logic [IW+1:0]     base_s;
  logic [3:0]        a_slice_s;
  logic [3:0]        b_slice_s;
  logic [4:0]        slice_sum_s;
  logic              last_slice_s;

  // Operands are only taken in IDLE and never while reset is applied.
  assign in_ready  = (state_r == ST_IDLE) && !rst;

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign busy      = busy_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last slice,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Select the current 4-bit slice of each captured operand and add it with
  // the running carry as a 5-bit unsigned sum.
  always_comb begin
    base_s       = {idx_r, 2'b00};
    a_slice_s    = a_r[base_s +: 4];
    b_slice_s    = b_r[base_s +: 4];
    slice_sum_s  = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {4'b0000, carry_r};
    last_slice_s = (idx_r == LAST_IDX);
  end

  // Datapath: operand capture, per-slice sum write-back, carry chain and the
  // output handshake flag. Inputs only reach these registers in IDLE, so later
  // changes on a/b/cin cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      idx_r       <= IDX_ZERO;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= IDX_ZERO;
          end
        end
        ST_RUN: begin
          sum_r[base_s +: 4] <= slice_sum_s[3:0];
          carry_r            <= slice_sum_s[4];
          idx_r              <= idx_r + IDX_ONE;
          if (last_slice_s) begin
            cout_r      <= slice_sum_s[4];
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16). Stimulus pushes the
// hand-computed result of every accepted operation into a queue; a monitor
// pops and compares whenever the output handshake completes.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  // expected {sum, cout}
  logic [16:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every completed output handshake against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_output: actual sum=0x%0h cout=%0d required no output", sum, cout);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[16:1]));
        check("cout", 32'(cout), 32'(e[0]));
      end
    end
  end

  // Present operands, wait for in_ready (bounded), optionally push the
  // expected result, and return after the accept edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input bit push, input logic [15:0] es, input logic ec,
                       output int waited);
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: actual in_ready=0 required 1 within 50 cycles");
    end
    if (push) exp_q.push_back({es, ec});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    int n_acc;
    int ov;
    int last_acc;

    rst = 1'b1;
    in_valid = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    cin = 1'b0;
    out_ready = 1'b1;

    // reset state
    tick();
    tick();
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // basic add and latency
    issue(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, w);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_in_run", 32'(in_ready), 32'd0);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt < 20);
    check("latency", 32'(cnt), 32'd4);
    drain();

    // full carry propagation
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, w);
    drain();
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, w);
    drain();

    // backpressure in DONE with a pending request
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, w);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    in_valid = 1'b1;
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h3333);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h1010, 1'b0, w);
    check("bp_wait_to_idle", 32'(w), 32'd1);
    drain();

    // reset in the middle of RUN (sampled at the 2nd RUN edge)
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, w);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_pulse", 32'(out_valid), 32'd0);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, w);
    drain();

    // back-to-back with in_valid and out_ready held high
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    out_ready = 1'b1;
    n_acc = 0;
    ov = 0;
    last_acc = -1;
    for (int cyc = 0; cyc < 19; cyc++) begin
      if (in_ready) begin
        exp_q.push_back({16'h0000, 1'b1});
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid) ov++;
      tick();
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_out_valid_cycles", 32'(ov), 32'd3);
    drain();

    // operand change during RUN has no effect
    issue(16'h1000, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, w);
    tick();
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    drain();

    for (int i = 0; i < 3; i++) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
